// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and outcome bundle of the PS/2 host transmitter.
// The master offers a byte; the slave (transmitter) reports readiness and outcome pulses.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_err,
        input  timeout
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_err,
        output timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-bit frame driven on
// device clock falling edges, ack sampling, and an overall transfer timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_CYCLES   = 200,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int PH_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PH_W-1:0] INH_LAST   = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0] START_LAST = PH_W'(START_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_TX,
        S_WAIT_ACK,
        S_WAIT_IDLE
    } state_t;

    // Index 0 = PS2Clk, index 1 = PS2Data; both lines share the same 2-flop synchronizer.
    logic [1:0] w_pad;
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic       r_clk_prev;
    logic       w_clk_s;
    logic       w_data_s;
    logic       w_fall;

    assign w_pad = {ps2_data_i, ps2_clk_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_meta[gi] <= 1'b1;
                    r_sync[gi] <= 1'b1;
                end else begin
                    r_meta[gi] <= w_pad[gi];
                    r_sync[gi] <= r_meta[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= r_sync[0];
        end
    end

    assign w_clk_s  = r_sync[0];
    assign w_data_s = r_sync[1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

    state_t           r_state;
    logic [9:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic [PH_W-1:0]  r_phase_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_ack_bad;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_tx_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_ack_err;
    logic             r_timeout;
    logic             w_to_counting;
    logic             w_to_hit;

    assign w_to_counting = (r_state == S_TX) || (r_state == S_WAIT_ACK) || (r_state == S_WAIT_IDLE);
    assign w_to_hit      = w_to_counting && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_phase_cnt <= '0;
            r_to_cnt    <= '0;
            r_ack_bad   <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_err   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;

            if (w_to_counting) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            // Timeout beats any falling edge in the same cycle; a NACKed byte ends silently.
            if (w_to_hit) begin
                r_clk_oe   <= 1'b0;
                r_data_oe  <= 1'b0;
                r_timeout  <= ~r_ack_bad;
                r_tx_ready <= 1'b1;
                r_busy     <= 1'b0;
                r_state    <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        if (bus.tx_valid) begin
                            // Frame after the start bit, LSB first: D0..D7, odd parity, stop.
                            r_shift     <= {1'b1, ~^bus.tx_data, bus.tx_data};
                            r_phase_cnt <= '0;
                            r_ack_bad   <= 1'b0;
                            r_clk_oe    <= 1'b1;
                            r_tx_ready  <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_INHIBIT;
                        end
                    end

                    S_INHIBIT: begin
                        if (r_phase_cnt == INH_LAST) begin
                            r_phase_cnt <= '0;
                            r_data_oe   <= 1'b1;
                            r_state     <= S_START;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + 1'b1;
                        end
                    end

                    S_START: begin
                        if (r_phase_cnt == START_LAST) begin
                            r_phase_cnt <= '0;
                            r_clk_oe    <= 1'b0;
                            r_bit_cnt   <= '0;
                            r_to_cnt    <= '0;
                            r_state     <= S_TX;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + 1'b1;
                        end
                    end

                    S_TX: begin
                        if (w_fall) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[9:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 4'd9) begin
                                r_state <= S_WAIT_ACK;
                            end
                        end
                    end

                    S_WAIT_ACK: begin
                        r_data_oe <= 1'b0;
                        if (w_fall) begin
                            if (w_data_s) begin
                                r_ack_err <= 1'b1;
                                r_ack_bad <= 1'b1;
                            end
                            r_state <= S_WAIT_IDLE;
                        end
                    end

                    S_WAIT_IDLE: begin
                        if (w_clk_s && w_data_s) begin
                            r_done     <= ~r_ack_bad;
                            r_tx_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end

                    default: begin
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_oe   = r_clk_oe;
    assign ps2_data_oe  = r_data_oe;
    assign bus.tx_ready = r_tx_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.ack_err  = r_ack_err;
    assign bus.timeout  = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain line model plus a device clocking BFM,
// a vector table for whole-byte transfers and hand sequences for reset and timeout corners.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int ST   = 4;
    localparam int TO   = 5000;
    localparam int HALF = 40;

    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_NOCLK = 2;
    localparam int M_COINC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic clk_oe;
    logic data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_line;
    logic ps2_data_line;

    assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_CYCLES(ST),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .ps2_clk_i(ps2_clk_line),
        .ps2_data_i(ps2_data_line),
        .ps2_clk_oe(clk_oe),
        .ps2_data_oe(data_oe)
    );

    int n_checks = 0;
    int n_err = 0;
    int c_done = 0;
    int c_err = 0;
    int c_to = 0;

    typedef struct {
        logic [7:0] data;
        int         mode;
        bit         keep;
        logic [7:0] next_d;
        logic [9:0] exp_cap;
        int         exp_done;
        int         exp_err;
        int         exp_to;
    } vec_t;

    localparam int NV = 6;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.done)    c_done++;
        if (bus.ack_err) c_err++;
        if (bus.timeout) c_to++;
    endtask

    // One device clock pulse; returns the data line level at the rising edge.
    task automatic dev_pulse(output logic b);
        dev_clk_low = 1'b1;
        repeat (HALF) tick();
        dev_clk_low = 1'b0;
        b = ps2_data_line;
        repeat (HALF) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input int mode, input bit keep,
                             input logic [7:0] nd, output logic [9:0] cap,
                             output int inh, output int st, output int lat);
        int   guard;
        logic b;
        c_done = 0;
        c_err  = 0;
        c_to   = 0;
        cap    = '0;
        inh    = 0;
        st     = 0;
        lat    = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        guard = 0;
        while (!bus.tx_ready && guard < 20000) begin
            tick();
            guard++;
        end
        tick();
        bus.tx_valid = keep;
        bus.tx_data  = nd;
        guard = 0;
        while (clk_oe && !data_oe && guard < 1000) begin
            inh++;
            tick();
            guard++;
        end
        while (clk_oe && data_oe && guard < 1000) begin
            st++;
            tick();
            guard++;
        end
        if (mode == M_ACK || mode == M_NACK) begin
            repeat (10) tick();
            for (int p = 1; p <= 11; p++) begin
                dev_pulse(b);
                if (p <= 10) cap[p-1] = b;
                if (p == 10 && mode == M_ACK) dev_data_low = 1'b1;
            end
            dev_data_low = 1'b0;
            guard = 0;
            while ((c_done + c_err + c_to) == 0 && guard < 2000) begin
                tick();
                guard++;
            end
        end else begin
            while (!bus.timeout && lat < TO + 1000) begin
                if (mode == M_COINC && lat == TO - 3) dev_clk_low = 1'b1;
                tick();
                lat++;
            end
            dev_clk_low = 1'b0;
        end
    endtask

    logic [9:0] cap;
    int inh;
    int st;
    int lat;
    logic b;

    initial begin
        vec[0] = '{8'hF4, M_ACK,   1'b0, 8'h00, 10'h2F4, 1, 0, 0};
        vec[1] = '{8'h00, M_ACK,   1'b1, 8'hFF, 10'h300, 1, 0, 0};
        vec[2] = '{8'hFF, M_ACK,   1'b0, 8'h00, 10'h3FF, 1, 0, 0};
        vec[3] = '{8'hA5, M_NACK,  1'b0, 8'h00, 10'h3A5, 0, 1, 0};
        vec[4] = '{8'h01, M_NOCLK, 1'b0, 8'h00, 10'h000, 0, 0, 1};
        vec[5] = '{8'hF4, M_COINC, 1'b0, 8'h00, 10'h000, 0, 0, 1};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx_ready", bus.tx_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_oe", {clk_oe, data_oe}, 0);
        chk("reset_pulses", {bus.done, bus.ack_err, bus.timeout}, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < NV; i++) begin
            send_byte(vec[i].data, vec[i].mode, vec[i].keep, vec[i].next_d, cap, inh, st, lat);
            chk("inhibit_cycles", inh, INH);
            chk("start_cycles", st, ST);
            chk("end_oe", {clk_oe, data_oe}, 0);
            chk("end_tx_ready", bus.tx_ready, 1);
            if (vec[i].exp_to == 0) chk("captured_frame", cap, vec[i].exp_cap);
            else                    chk("timeout_latency", lat, TO);
            if (!vec[i].keep) begin
                repeat (200) tick();
                chk("idle_tx_ready", bus.tx_ready, 1);
            end
            chk("done_count", c_done, vec[i].exp_done);
            chk("ack_err_count", c_err, vec[i].exp_err);
            chk("timeout_count", c_to, vec[i].exp_to);
            $display("txn %0d data=%02h mode=%0d cap=%03h inh=%0d start=%0d done=%0d ack_err=%0d timeout=%0d lat=%0d",
                     i, vec[i].data, vec[i].mode, cap, inh, st, c_done, c_err, c_to, lat);
        end

        // Asynchronous reset in the middle of the frame, after the fourth data edge.
        bus.tx_data  = 8'hF4;
        bus.tx_valid = 1'b1;
        tick();
        tick();
        bus.tx_valid = 1'b0;
        for (int g = 0; g < 1000 && clk_oe; g++) tick();
        repeat (10) tick();
        for (int p = 1; p <= 4; p++) dev_pulse(b);
        chk("pre_reset_busy", bus.busy, 1);
        chk("pre_reset_data_oe", data_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_oe", {clk_oe, data_oe}, 0);
        chk("async_reset_ready", {bus.tx_ready, bus.busy}, 2'b10);
        $display("txn reset_mid_tx oe=%b%b ready=%b busy=%b", clk_oe, data_oe, bus.tx_ready, bus.busy);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        send_byte(8'hF4, M_ACK, 1'b0, 8'h00, cap, inh, st, lat);
        repeat (50) tick();
        chk("post_reset_frame", cap, 10'h2F4);
        chk("post_reset_done", c_done, 1);
        chk("post_reset_errs", c_err + c_to, 0);
        $display("txn post_reset data=f4 cap=%03h done=%0d ack_err=%0d timeout=%0d", cap, c_done, c_err, c_to);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
